// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states and scan-code constants.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_t;

  // Break prefix sent before the scan code of a released key.
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  // Extended-key prefix; always passed through untouched.
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataBits, input logic parityBit);
    return ^{dataBits, parityBit};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Cleans one raw PS/2 line: 2-flop synchronizer followed by a FILTER_LEN-deep agreement filter.
// Latency: FILTER_LEN+3 Clock cycles from a stable pin change to oLine.
// Backpressure: none; the output simply follows the line once it has been stable long enough.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iLine,
  output logic oLine
);

  logic                  syncMeta;
  logic                  syncOut;
  logic [FILTER_LEN-1:0] history;

  // Two-flop synchronizer; presets high because an idle PS/2 line is pulled up.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      syncMeta <= 1'b1;
      syncOut  <= 1'b1;
    end else begin
      syncMeta <= iLine;
      syncOut  <= syncMeta;
    end
  end

  // Sample history of the synchronized line, newest sample in bit 0.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      history <= '1;
    end else begin
      history <= {history[FILTER_LEN-2:0], syncOut};
    end
  end

  // Filtered level moves only when every sample in the history agrees; otherwise it holds.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oLine <= 1'b1;
    end else if (&history) begin
      oLine <= 1'b1;
    end else if (~|history) begin
      oLine <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: filters the lines, deframes 11-bit frames and buffers scan codes in a show-ahead FIFO.
// Latency: oValid rises 2 Clock cycles after the stop-bit clock tick (FILTER_LEN+5 cycles after the PS2_CLK pin falls).
// Backpressure: none toward the keyboard; a byte arriving at a full FIFO is dropped and oOverflow is set.
// Build option: define PS2_BREAK_FILTER_EN to drop each 8'hF0 break prefix and the byte that follows it.
module ps2_keyboard_rx
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       iRead,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oOverflow
);

  import ps2_pkg::*;

  // FIFO_DEPTH must be a power of two of at least 2 so the pointers wrap by overflow.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic            clkFilt;
  logic            dataFilt;
  logic            clkPrev;
  logic            fallTick;

  ps2State_t       state;
  ps2State_t       stateNext;
  logic [2:0]      bitCnt;
  logic [7:0]      shiftReg;
  logic            frameBad;
  logic [TO_W-1:0] idleCnt;
  logic            timeoutHit;

  logic            startFrame;
  logic            shiftBit;
  logic            parityFail;
  logic            stopGood;
  logic            frameErrNext;

  logic            pushReq;
  logic [7:0]      pushByte;

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             fifoFull;
  logic             doPush;
  logic             doPop;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
    .Clock (Clock),
    .Reset (Reset),
    .iLine (PS2_CLK),
    .oLine (clkFilt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilter (
    .Clock (Clock),
    .Reset (Reset),
    .iLine (PS2_DATA),
    .oLine (dataFilt)
  );

  // Previous filtered clock level, used to find the falling edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      clkPrev <= 1'b1;
    end else begin
      clkPrev <= clkFilt;
    end
  end

  assign fallTick   = clkPrev & ~clkFilt;
  assign timeoutHit = (state != IDLE) && !fallTick && (idleCnt == TO_LAST);

  // Frame FSM state register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Frame FSM next state: advance on clock ticks, abort to IDLE on timeout.
  always_comb begin
    stateNext = state;
    if (timeoutHit) begin
      stateNext = IDLE;
    end else if (fallTick) begin
      case (state)
        IDLE:    if (!dataFilt) stateNext = DATA;
        DATA:    if (bitCnt == 3'd7) stateNext = PARITY;
        PARITY:  stateNext = STOP;
        STOP:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Frame FSM outputs: datapath controls and the error strobe for this cycle.
  always_comb begin
    startFrame   = 1'b0;
    shiftBit     = 1'b0;
    parityFail   = 1'b0;
    stopGood     = 1'b0;
    frameErrNext = timeoutHit;
    if (fallTick) begin
      case (state)
        IDLE:   startFrame = !dataFilt;
        DATA:   shiftBit   = 1'b1;
        PARITY: begin
          parityFail   = !oddParityOk(shiftReg, dataFilt);
          frameErrNext = !oddParityOk(shiftReg, dataFilt);
        end
        STOP: begin
          stopGood     = dataFilt && !frameBad;
          frameErrNext = !dataFilt;
        end
        default: ;
      endcase
    end
  end

  // Deframing datapath: LSB-first shift register, bit counter and bad-frame marker.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      bitCnt   <= 3'd0;
      shiftReg <= 8'h00;
      frameBad <= 1'b0;
    end else if (startFrame || timeoutHit) begin
      bitCnt   <= 3'd0;
      shiftReg <= 8'h00;
      frameBad <= 1'b0;
    end else begin
      if (shiftBit) begin
        shiftReg <= {dataFilt, shiftReg[7:1]};
        bitCnt   <= bitCnt + 3'd1;
      end
      if (parityFail) begin
        frameBad <= 1'b1;
      end
    end
  end

  // Cycles spent inside a frame since the last clock tick.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      idleCnt <= '0;
    end else if ((state == IDLE) || fallTick || timeoutHit) begin
      idleCnt <= '0;
    end else begin
      idleCnt <= idleCnt + TO_W'(1);
    end
  end

  // Registered error pulse; reset clears it so an aborted frame never reports an error.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oFrameErr <= 1'b0;
    end else begin
      oFrameErr <= frameErrNext;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic skipNext;

  // Push stage: swallow the break prefix and the scan code that follows it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pushReq  <= 1'b0;
      pushByte <= 8'h00;
      skipNext <= 1'b0;
    end else begin
      pushReq <= 1'b0;
      if (stopGood) begin
        pushByte <= shiftReg;
        if (skipNext) begin
          skipNext <= 1'b0;
        end else if (shiftReg == PS2_BREAK) begin
          skipNext <= 1'b1;
        end else begin
          pushReq <= 1'b1;
        end
      end
    end
  end
`else
  // Push stage: every correctly framed byte is queued one cycle after its stop tick.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pushReq  <= 1'b0;
      pushByte <= 8'h00;
    end else begin
      pushReq <= stopGood;
      if (stopGood) begin
        pushByte <= shiftReg;
      end
    end
  end
`endif

  assign oValid   = (count != '0);
  assign fifoFull = (count == CNT_FULL);
  assign doPop    = iRead && oValid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign doPush   = pushReq && (!fifoFull || doPop);
  assign oData    = oValid ? fifoMem[rdPtr] : 8'h00;

  // FIFO storage write.
  always_ff @(posedge Clock) begin
    if (doPush) begin
      fifoMem[wrPtr] <= pushByte;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set when a byte is dropped, cleared only by reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oOverflow <= 1'b0;
    end else if (pushReq && fifoFull && !doPop) begin
      oOverflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed PS/2 frames, scoreboard queue of expected bytes, independent pop monitor.
// Latency: expects oValid FILTER_LEN+5 cycles after the stop-bit PS2_CLK fall.
// Backpressure: the monitor pops whenever reads are enabled; reads are held off to fill the FIFO.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 50000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       iRead = 1'b0;
  logic [7:0] oData;
  logic       oValid;
  logic       oFrameErr;
  logic       oOverflow;

  int checks = 0;
  int errors = 0;
  int errCycles = 0;
  int expErr = 0;
  int cycleCount = 0;
  int lastFall = 0;
  int lastPopCycle = 0;
  bit readEn = 1'b0;
  logic [7:0] expQ[$];

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .PS2_CLK   (ps2Clk),
    .PS2_DATA  (ps2Data),
    .iRead     (iRead),
    .oData     (oData),
    .oValid    (oValid),
    .oFrameErr (oFrameErr),
    .oOverflow (oOverflow)
  );

  always #10 Clock = ~Clock;

  // Number of rising Clock edges so far.
  always @(posedge Clock) cycleCount <= cycleCount + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: counts error-pulse cycles and pops/compares every byte the DUT presents.
  initial begin
    logic [7:0] expByte;
    forever begin
      @(negedge Clock);
      iRead = 1'b0;
      if (oFrameErr) errCycles++;
      if (readEn && oValid) begin
        lastPopCycle = cycleCount;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", oData);
        end else begin
          expByte = expQ.pop_front();
          check("pop_data", int'(oData), int'(expByte));
        end
        iRead = 1'b1;
      end
    end
  end

  // One PS/2 bit: data set while the clock is high, then a 20-cycle low phase.
  task automatic sendBit(input logic b);
    ps2Data = b;
    repeat (10) @(negedge Clock);
    ps2Clk = 1'b0;
    lastFall = cycleCount;
    repeat (20) @(negedge Clock);
    ps2Clk = 1'b1;
    repeat (10) @(negedge Clock);
  endtask

  // Sends the first nBits of a frame: start, 8 data LSB first, parity (odd, optionally flipped), stop.
  task automatic sendFrame(input logic [7:0] d, input logic parFlip, input logic stopBit, input int nBits);
    logic [10:0] bits;
    bits = {stopBit, (~(^d)) ^ parFlip, d, 1'b0};
    for (int i = 0; i < nBits; i++) sendBit(bits[i]);
    ps2Data = 1'b1;
    repeat (40) @(negedge Clock);
  endtask

  task automatic sendGood(input logic [7:0] d);
    expQ.push_back(d);
    sendFrame(d, 1'b0, 1'b1, 11);
  endtask

  initial begin
    logic [7:0] patterns [5];
    bit gotErr;
    patterns[0] = 8'h00; patterns[1] = 8'hFF; patterns[2] = 8'hA5;
    patterns[3] = 8'h80; patterns[4] = 8'hE0;

    // Reset state
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    check("reset_valid", int'(oValid), 0);
    check("reset_data", int'(oData), 0);
    check("reset_frameerr", int'(oFrameErr), 0);
    check("reset_overflow", int'(oOverflow), 0);
    Reset = 1'b1;
    repeat (20) @(negedge Clock);
    readEn = 1'b1;

    // Good 0x1C frame and its latency: tick after FILTER_LEN+3 edges, then 2 more cycles to oValid
    sendGood(8'h1C);
    check("latency_1C", lastPopCycle - lastFall, FILTER_LEN + 5);
    check("err_1C", errCycles, expErr);
    check("queue_1C", expQ.size(), 0);

    // Wrong parity: one error pulse, nothing queued
    sendFrame(8'h1C, 1'b1, 1'b1, 11);
    expErr++;
    check("err_parity", errCycles, expErr);
    check("valid_parity", int'(oValid), 0);

    // Assorted byte patterns, including the extended prefix
    for (int i = 0; i < 5; i++) sendGood(patterns[i]);
    check("queue_patterns", expQ.size(), 0);
    check("err_patterns", errCycles, expErr);

    // Break prefix followed by a scan code
`ifndef PS2_BREAK_FILTER_EN
    expQ.push_back(8'hF0);
    expQ.push_back(8'h1C);
`endif
    sendFrame(8'hF0, 1'b0, 1'b1, 11);
    sendFrame(8'h1C, 1'b0, 1'b1, 11);
    check("queue_break", expQ.size(), 0);
    check("valid_break", int'(oValid), 0);

    // Stop bit low: error pulse, byte dropped
    sendFrame(8'h44, 1'b0, 1'b0, 11);
    expErr++;
    check("err_stop", errCycles, expErr);
    check("valid_stop", int'(oValid), 0);

    // Overflow: five bytes into a four-deep FIFO with reads held off
    check("overflow_before", int'(oOverflow), 0);
    readEn = 1'b0;
    for (int i = 1; i <= 5; i++) sendFrame(8'(i), 1'b0, 1'b1, 11);
    check("overflow_set", int'(oOverflow), 1);
    check("overflow_valid", int'(oValid), 1);
    for (int i = 1; i <= 4; i++) expQ.push_back(8'(i));
    readEn = 1'b1;
    repeat (10) @(negedge Clock);
    check("overflow_queue", expQ.size(), 0);
    check("overflow_drained", int'(oValid), 0);

    // Timeout: start plus 4 data bits, then silence; error follows the last tick by TIMEOUT_CYCLES+1
    sendFrame(8'h77, 1'b0, 1'b1, 5);
    gotErr = 1'b0;
    for (int i = 0; i < TIMEOUT_CYCLES + 1000; i++) begin
      @(negedge Clock);
      if (oFrameErr) begin
        gotErr = 1'b1;
        break;
      end
    end
    expErr++;
    check("timeout_seen", int'(gotErr), 1);
    check("timeout_latency", cycleCount - lastFall, TIMEOUT_CYCLES + FILTER_LEN + 4);
    repeat (5) @(negedge Clock);
    check("err_timeout", errCycles, expErr);
    sendGood(8'h32);
    check("queue_after_timeout", expQ.size(), 0);
    check("err_after_timeout", errCycles, expErr);

    // Reset in the middle of a frame: no error, FIFO empty, sticky overflow cleared
    sendFrame(8'h33, 1'b0, 1'b1, 6);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    repeat (20) @(negedge Clock);
    check("err_midreset", errCycles, expErr);
    check("valid_midreset", int'(oValid), 0);
    check("overflow_midreset", int'(oOverflow), 0);
    sendGood(8'h5A);
    check("queue_after_reset", expQ.size(), 0);
    check("err_after_reset", errCycles, expErr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (95000) @(posedge Clock);
    errors++;
    $display("FAIL watchdog: got no completion, expected completion within 95000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal samples needed before a filtered PS/2 line changes level.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two: number of scan-code bytes buffered.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle Clock cycles allowed inside a frame before it is aborted.
REQ-004 Clock  input  1  system clock (50 MHz); only clock in the block.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 PS2_CLK  input  1  raw asynchronous PS/2 clock line.
REQ-007 PS2_DATA  input  1  raw asynchronous PS/2 data line.
REQ-008 iRead  input  1  pop strobe from the ALU TEC instruction; consumes the head byte.
REQ-009 oData  output  8  head scan code, valid while oValid=1 (show-ahead).
REQ-010 oValid  output  1  FIFO not empty.
REQ-011 oFrameErr  output  1  one-cycle pulse on start, parity, stop or timeout error.
REQ-012 oOverflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-013 Each PS/2 line SHALL pass through a 2-flop synchronizer, then a FILTER_LEN-deep shift filter; the filtered level changes only when all FILTER_LEN samples agree.
REQ-014 A one-cycle fall tick SHALL be generated on each 1->0 transition of filtered PS2_CLK; filtered PS2_DATA is sampled on that cycle.
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on tick with data=0 go DATA with bit count 0; on tick with data=1 stay IDLE with no error.
REQ-017 DATA: shift the 8 bits in LSB first; after the 8th tick go PARITY.
REQ-018 PARITY: on tick, the 8 data bits plus the parity bit SHALL contain an odd number of ones; otherwise pulse oFrameErr and mark the frame bad; go STOP.
REQ-019 STOP: on tick, data=1 and frame not bad -> push byte on the next cycle; data=0 -> pulse oFrameErr; both cases go IDLE.
REQ-020 In any non-IDLE state, TIMEOUT_CYCLES cycles without a tick SHALL abort to IDLE, pulse oFrameErr, and discard partial bits.
REQ-021 Latency: oValid SHALL assert 2 Clock cycles after the stop-bit tick when the FIFO was empty.
REQ-022 iRead with oValid=1 SHALL advance the head on the next edge; iRead with oValid=0 SHALL be ignored.
REQ-023 Push while full without a simultaneous pop SHALL drop the byte and set oOverflow; push and pop in the same cycle while full SHALL both succeed.
REQ-024 The read and write pointers SHALL wrap modulo FIFO_DEPTH, with the occupancy count held in $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-025 While Reset=0 at a Clock edge: FSM=IDLE, FIFO empty, oValid=0, oData=8'h00, oFrameErr=0, oOverflow=0, filters preset to 1 (idle-high lines), timeout counter 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no oFrameErr pulse.

Configuration
REQ-027 With PS2_BREAK_FILTER_EN defined: byte 8'hF0 and the single byte following it SHALL NOT be pushed, so only make codes reach the FIFO; 8'hE0 is pushed unchanged.
REQ-028 Without PS2_BREAK_FILTER_EN: every correctly framed byte SHALL be pushed.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the FSM state typedef, PS2_BREAK=8'hF0 and PS2_EXTEND=8'hE0.
REQ-030 Synchronizer plus filter SHALL be sub-module ps2_line_filter, instantiated once for PS2_CLK and once for PS2_DATA.

Verification
REQ-031 Frame 0x1C with parity 0 and stop 1 -> oData=8'h1C; oValid rises 2 cycles after the stop tick; oFrameErr stays 0.
REQ-032 Frame 0x1C with parity 1 -> oFrameErr pulses once; oValid stays 0.
REQ-033 Five frames 0x01..0x05 with FIFO_DEPTH=4 and no reads -> oOverflow=1; pops return 01,02,03,04 and oValid then falls.
REQ-034 Bytes F0,1C with the macro defined -> FIFO empty. Same bytes without the macro -> pops return F0 then 1C.
REQ-035 Stop after 4 data bits -> after 50000 idle cycles oFrameErr pulses; a following 0x32 frame is received correctly.
REQ-036 Reset=0 during bit 5 of a frame, then release -> no oFrameErr pulse, FIFO empty, next frame received correctly.
